// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor sequencer: A - B - bin_init, LSB first.
// Drives an external 1-bit full-subtractor cell through fs_* and assembles its
// Diff bits into the result, with a start/busy/done handshake.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_diff,
  input  logic             fs_bout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, d_sr_q;
  logic             brw_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             last_bit;
  logic [WIDTH-1:0] d_sr_next;

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  // Incoming Diff bit enters at the MSB so the LSB-first stream lands in place.
  assign d_sr_next = {fs_diff, d_sr_q[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake / cell-facing outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    fs_a    = 1'b0;
    fs_b    = 1'b0;
    fs_bin  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        busy   = 1'b1;
        fs_a   = a_sr_q[0];
        fs_b   = b_sr_q[0];
        fs_bin = brw_q;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, serial shifting, borrow chaining and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      d_sr_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        a_sr_q <= a;
        b_sr_q <= b;
        brw_q  <= bin_init;
        cnt_q  <= '0;
      end else if (state_q == StRun) begin
        a_sr_q <= a_sr_q >> 1;
        b_sr_q <= b_sr_q >> 1;
        d_sr_q <= d_sr_next;
        brw_q  <= fs_bout;
        cnt_q  <= cnt_q + CntW'(1);
        // Result only moves here, so it holds through IDLE and the next RUN.
        if (last_bit) begin
          diff_q <= d_sr_next;
          bout_q <= fs_bout;
        end
      end
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8) with a behavioural
// full-subtractor cell on the fs_* ports and an arithmetic reference model.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin_init = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  logic         fs_a, fs_b, fs_bin, fs_diff, fs_bout;

  int n_checks = 0;
  int n_errors = 0;

  logic         mon_en = 1'b0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin_init (bin_init),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .fs_a     (fs_a),
    .fs_b     (fs_b),
    .fs_bin   (fs_bin),
    .fs_diff  (fs_diff),
    .fs_bout  (fs_bout)
  );

  // Behavioural 1-bit full subtractor cell.
  assign fs_diff = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic and an integer comparison for the borrow.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic bi);
    int r;
    r = (int'(x) - int'(y) - int'(bi)) & ((1 << W) - 1);
    return r[W-1:0];
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic bi);
    return int'(x) < int'(y) + int'(bi);
  endfunction

  // Cell inputs must be quiet outside RUN; result must only move on a done cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!(busy && !done)) check("fs_quiet", {29'd0, fs_a, fs_b, fs_bin}, 32'd0);
      if (done) last_diff <= diff;
      else check("diff_stable", diff, last_diff);
    end
  end

  // Caller is #1 after a posedge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    int cyc;
    a = ai;
    b = bi;
    bin_init = bini;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin_init = 1'($urandom);
    check("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, W);
    check("diff", diff, ref_diff(ai, bi, bini));
    check("bout", bout, ref_bout(ai, bi, bini));
    @(posedge clk);
    #1;
    check("done_width", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int gap;

    // Reset state.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_fs", {fs_a, fs_b, fs_bin}, 0);
    #20;
    @(posedge clk);
    rst_n = 1'b1;
    #1;

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0);
    check("t1_diff", diff, 8'h1E);
    check("t1_bout", bout, 0);
    run_op(8'h00, 8'h01, 1'b0);
    check("t2a_diff", diff, 8'hFF);
    check("t2a_bout", bout, 1);
    run_op(8'hFF, 8'hFF, 1'b1);
    check("t2b_diff", diff, 8'hFF);
    check("t2b_bout", bout, 1);

    // start pulsed while running is ignored.
    a = 8'h10;
    b = 8'h01;
    bin_init = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      start = (cyc == 3 || cyc == 6);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("t3_latency", cyc, W);
    check("t3_diff", diff, 8'h0F);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || (i > 0 && busy)) n_done++;
    end
    check("t3_no_second_run", n_done, 0);

    // Asynchronous reset mid-operation.
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_diff", diff, 0);
    check("t4_bout", bout, 0);
    check("t4_fs", {fs_a, fs_b, fs_bin}, 0);
    #10;
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    run_op(8'hC4, 8'h2B, 1'b1);
    check("t4_after_diff", diff, 8'h98);

    // start held high: back-to-back ops, accepted in the IDLE cycle after DONE.
    a = 8'h80;
    b = 8'h7F;
    bin_init = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h01;
    b = 8'h02;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t5a_latency", cyc, W);
    check("t5a_diff", diff, 8'h01);
    check("t5a_bout", bout, 0);
    cyc = 0;
    @(posedge clk);
    #1;
    cyc++;
    while (!done && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    // DONE, IDLE, then WIDTH RUN cycles: done-to-done is WIDTH+2 edges.
    check("t5_spacing", cyc, W + 2);
    check("t5b_diff", diff, 8'hFF);
    check("t5b_bout", bout, 1);
    @(posedge clk);
    #1;

    // Random operations with monitors enabled.
    last_diff = diff;
    mon_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
